// File: rtl/lcg_stim_pkg.sv
// Shared constants, FSM state type and sizing helper for the LCG stimulus generator.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StOffer,
    StDone
  } state_e;

  function automatic int unsigned nw(input int unsigned width);
    return (width + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// Combinational LCG next-state: x' = x * LCG_MUL + LCG_INC (mod 2^32).
module lcg_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] state_i,
  output logic [31:0] state_o
);

  assign state_o = state_i * LCG_MUL + LCG_INC;

endmodule

// File: rtl/lcg_stim_gen.sv
// Fills an IN_W-bit vector one LCG word per cycle, then offers it with a valid/ready handshake.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned IN_W         = 269,
  parameter logic [31:0] SEED_DEFAULT = 32'd677517496
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_load,
  input  logic [31:0]     seed_in,
  input  logic            start,
  input  logic [31:0]     cycles,
  output logic            vec_valid,
  input  logic            vec_ready,
  output logic [IN_W-1:0] vec_data,
  output logic            busy,
  output logic            done,
  output logic [31:0]     vec_count
);

  localparam int unsigned NW = nw(IN_W);
  localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NW - 1);

  state_e          state_q, state_d;
  logic [31:0]     x_q, x_d, x_next;
  logic [IN_W-1:0] vec_q, vec_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     remaining_q, remaining_d;
  logic [31:0]     count_q, count_d;

  lcg_step u_step (
    .state_i(x_q),
    .state_o(x_next)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    vec_d       = vec_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          x_d = seed_in;
        end else if (start) begin
          remaining_d = cycles;
          count_d     = '0;
          idx_d       = '0;
          state_d     = (cycles == 32'd0) ? StDone : StFill;
        end
      end
      StFill: begin
        x_d = x_next;
        // Word k lands in bits [32k+31:32k]; bits past IN_W are dropped.
        for (int k = 0; k < int'(NW); k++) begin
          if (idx_q == IdxW'(k)) begin
            for (int j = 0; j < 32; j++) begin
              if (32 * k + j < int'(IN_W)) vec_d[32*k+j] = x_next[j];
            end
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (vec_ready) begin
          count_d = count_q + 32'd1;
          if (remaining_q != 32'd0) remaining_d = remaining_q - 32'd1;
          state_d = (remaining_q <= 32'd1) ? StDone : StFill;
        end
      end
      StDone: begin
        if (start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= SEED_DEFAULT;
      vec_q       <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      vec_q       <= vec_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  assign vec_valid = (state_q == StOffer);
  assign busy      = (state_q == StFill) || (state_q == StOffer);
  assign done      = (state_q == StDone);
  assign vec_data  = vec_q;
  assign vec_count = count_q;

endmodule

// File: doc/lcg_stim_gen.md
LCG_STIM_GEN -- requirements
Module: lcg_stim_gen

Interface
REQ-001 Parameter IN_W, default 269, SHALL set the stimulus vector width in bits.
REQ-002 Parameter SEED_DEFAULT, default 677517496, SHALL set the 32-bit LCG state loaded by reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 seed_load  input  1  SHALL request loading of seed_in into the LCG state.
REQ-006 seed_in  input  32  SHALL carry the seed value.
REQ-007 start  input  1  SHALL request a run.
REQ-008 cycles  input  32  SHALL give the number of vectors to emit; it is sampled with start.
REQ-009 vec_valid  output  1  SHALL indicate that vec_data holds a complete vector.
REQ-010 vec_ready  input  1  SHALL indicate that the downstream DUT driver accepts the vector.
REQ-011 vec_data  output  IN_W  SHALL carry the stimulus vector bound for in_flat.
REQ-012 busy  output  1  SHALL be high in the FILL and OFFER states.
REQ-013 done  output  1  SHALL be high in the DONE state.
REQ-014 vec_count  output  32  SHALL give the number of vectors accepted in the current run.

Function
REQ-015 Each LCG step SHALL compute x <= (x*32'h41C64E6D + 32'h3039) mod 2^32, and the new x SHALL be the emitted word.
REQ-016 NW = ceil(IN_W/32) words SHALL form one vector.
  - Word k SHALL be written to bits [32k+31:32k].
  - The final word SHALL be truncated to its low (IN_W - 32*(NW-1)) bits.
REQ-017 The FSM SHALL have exactly four states: IDLE, FILL, OFFER, DONE.
REQ-018 IDLE transitions:
  - seed_load=1: load x <= seed_in and stay in IDLE.
  - else start=1: latch cycles into a remaining counter, clear vec_count, and go to FILL; if cycles=0, go directly to DONE instead.
  - If seed_load and start are both 1 in the same cycle, seed_load SHALL win and start SHALL be dropped.
REQ-019 FILL SHALL perform one LCG step per cycle, writing word k in the k-th FILL cycle, and SHALL go to OFFER after NW cycles.
REQ-020 OFFER transitions:
  - vec_valid=1.
  - On vec_valid && vec_ready: increment vec_count and decrement remaining.
  - If remaining becomes 0, go to DONE; otherwise go to FILL.
REQ-021 Latency: with start sampled at edge t, vec_valid SHALL first rise after edge t+NW; the first vector is acceptable at edge t+NW+1.
REQ-022 While vec_valid && !vec_ready, vec_data SHALL hold stable and no LCG step SHALL occur.
REQ-023 vec_data SHALL NOT change while in OFFER.
  - FILL overwrites words in place; vec_valid=0 throughout FILL.
REQ-024 DONE SHALL hold done=1, vec_count, and x.
  - start SHALL return the FSM to IDLE, where it is re-sampled on the next cycle; the LCG sequence continues from the current x.
REQ-025 seed_load and start SHALL be ignored in FILL and OFFER.
REQ-026 vec_ready SHALL be ignored outside OFFER.
REQ-027 vec_count SHALL wrap modulo 2^32.
REQ-028 remaining SHALL never underflow.

Reset
REQ-029 rst=1 SHALL force the following on the next edge regardless of state, including mid-FILL and mid-OFFER:
  - state=IDLE, x=SEED_DEFAULT.
  - vec_data=0, vec_valid=0, busy=0, done=0, vec_count=0, remaining=0.
REQ-030 rst SHALL take priority over seed_load and start in the same cycle.

Structure
REQ-031 Package lcg_stim_pkg SHALL hold:
  - LCG_MUL=32'h41C64E6D and LCG_INC=32'h3039.
  - The state enum type.
  - A function nw(width) returning ceil(width/32).
REQ-032 Sub-module lcg_step SHALL be the single sub-module: a combinational next-state function, 32 bits in, 32 bits out, instantiated once.

Verification
REQ-033 IN_W=64; seed_load with seed_in=0; start with cycles=1; vec_ready=1 -> one vector 64'hD3DC167E_00003039, then done=1 and vec_count=1.
REQ-034 Defaults; start with cycles=3; vec_ready=1 -> three vectors, each bit-exact against a software LCG from seed 677517496 (9 words per vector, word 8 masked to 13 bits); vec_valid high for exactly one cycle per vector.
REQ-035 cycles=2; vec_ready held 0 for 5 cycles after vec_valid rises -> vec_data unchanged across those cycles; second vector still matches words 9..17 of the sequence.
REQ-036 start with cycles=0 -> done=1 one cycle later; vec_valid never asserted; vec_count=0.
REQ-037 rst pulsed mid-FILL of the second vector -> next cycle IDLE, all outputs 0, x=SEED_DEFAULT; a new start reproduces the REQ-034 first vector.
REQ-038 seed_load=1 and start=1 in the same IDLE cycle -> seed loaded, no run started (busy stays 0); seed_load or start while busy -> no effect on vec_data or vec_count.
